// File: rtl/lane_id_pattern_checker_pkg.sv
// Shared definitions for the receive-side Lane ID pattern comparator used
// during MBINIT.REVERSALMB: FSM state encoding, Lane ID symbol format and the
// enable encoding driven by the partner-side state machine.
package lane_id_pattern_checker_pkg;

    // Comparator control flow: wait for enable, compare the run, hold the result
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Every Lane ID symbol is framed by this nibble on both ends
    localparam logic [3:0] LANEID_PREFIX = 4'hA;

    // One Lane ID symbol is 16 bits, transmitted MSB first
    localparam int SYMBOL_WIDTH = 16;
    localparam int BIT_IDX_W    = $clog2(SYMBOL_WIDTH);

    // Enable value that means "run the check"; anything else is idle/abort
    localparam logic [1:0] LANEID_EN_RUN = 2'b10;

    // Builds the symbol a given lane is expected to carry: prefix, lane number, suffix
    function automatic logic [SYMBOL_WIDTH-1:0] lane_id_symbol(input logic [7:0] lane);
        return {LANEID_PREFIX, lane, LANEID_PREFIX};
    endfunction

endpackage

// File: rtl/lane_id_lane_checker.sv
// Per-lane half of the Lane ID comparator. Tracks whether the symbol
// currently being received on this lane has seen a bit error, and counts how
// many whole symbols arrived error-free. The bit position being received is
// shared across all lanes and supplied by the top level.
module lane_id_lane_checker
    import lane_id_pattern_checker_pkg::*;
#(
    parameter int LANE_IDX   = 0,
    parameter int ITERATIONS = 128,
    parameter int MIN_MATCH  = 16,
    parameter int CNT_W      = $clog2(ITERATIONS + 1)
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_beat,
    input  logic [BIT_IDX_W-1:0] i_bit_idx,
    input  logic                 i_rx_bit,
    output logic                 o_pass_next
);

    // The symbol this lane must carry never changes, so it is fixed at elaboration
    localparam logic [SYMBOL_WIDTH-1:0] EXP_SYMBOL = lane_id_symbol(8'(LANE_IDX));
    localparam logic [CNT_W-1:0]        CNT_MAX    = CNT_W'(ITERATIONS);
    localparam logic [CNT_W-1:0]        CNT_PASS   = CNT_W'(MIN_MATCH);

    logic             r_err;
    logic [CNT_W-1:0] r_match_cnt;

    logic             w_expected_bit;
    logic             w_err_iter;
    logic             w_last_bit;
    logic             w_inc;
    logic [CNT_W-1:0] w_cnt_next;

    // Error status of the current symbol including the bit arriving now, and
    // the match count as it will stand once this beat is absorbed. The top
    // level samples the pass decision on the final beat, so it must already
    // include that beat's contribution.
    always_comb begin
        w_expected_bit = EXP_SYMBOL[i_bit_idx];
        w_err_iter     = r_err | (i_rx_bit != w_expected_bit);
        w_last_bit     = (i_bit_idx == '0);
        w_inc          = i_beat & w_last_bit & ~w_err_iter & (r_match_cnt != CNT_MAX);
        w_cnt_next     = w_inc ? (r_match_cnt + 1'b1) : r_match_cnt;
        o_pass_next    = (w_cnt_next >= CNT_PASS);
    end

    // Accumulate the error flag across a symbol, then fold it into the match
    // count on the last bit and start the next symbol with a clean flag.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_err       <= 1'b0;
            r_match_cnt <= '0;
        end else if (i_clear) begin
            r_err       <= 1'b0;
            r_match_cnt <= '0;
        end else if (i_beat) begin
            r_err       <= w_last_bit ? 1'b0 : w_err_iter;
            r_match_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/lane_id_pattern_checker.sv
// Receive-side Lane ID pattern comparator for MBINIT.REVERSALMB. Walks the
// shared bit position through ITERATIONS back-to-back Lane ID symbols, lets
// each lane checker score its own lane, and logs the per-lane pass vector
// with a one-cycle done pulse when the run completes.
module lane_id_pattern_checker
    import lane_id_pattern_checker_pkg::*;
#(
    parameter int NUM_LANES  = 16,
    parameter int ITERATIONS = 128,
    parameter int MIN_MATCH  = 16
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [1:0]           i_LaneID_Pattern_En,
    input  logic [1:0]           i_Clear_Pattern_Comparator,
    input  logic                 i_rx_valid,
    input  logic [NUM_LANES-1:0] i_rx_data,
    output logic [NUM_LANES-1:0] o_REVERSAL_Result_logged,
    output logic                 o_LaneID_Pattern_done,
    output logic                 o_busy
);

    localparam int                   ITER_W    = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [ITER_W-1:0]    LAST_ITER = ITER_W'(ITERATIONS - 1);
    localparam logic [BIT_IDX_W-1:0] FIRST_BIT = BIT_IDX_W'(SYMBOL_WIDTH - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [BIT_IDX_W-1:0]   r_bit_idx;
    logic [ITER_W-1:0]      r_iter;
    logic [NUM_LANES-1:0]   r_result;
    logic                   r_done;

    logic                   w_run;
    logic                   w_clear;
    logic                   w_start;
    logic                   w_beat;
    logic                   w_last_bit;
    logic                   w_final_beat;
    logic                   w_lane_clear;
    logic [NUM_LANES-1:0]   w_pass;

    // Event decode. Clear outranks everything: it blocks entry into CHECK and
    // suppresses any beat, including the one that would finish the run.
    // Dropping the enable in CHECK abandons the run, so that beat is ignored too.
    always_comb begin
        w_run        = (i_LaneID_Pattern_En == LANEID_EN_RUN);
        w_clear      = (i_Clear_Pattern_Comparator != 2'b00);
        w_start      = (r_state == ST_IDLE) & w_run & ~w_clear;
        w_beat       = (r_state == ST_CHECK) & w_run & ~w_clear & i_rx_valid;
        w_last_bit   = (r_bit_idx == '0);
        w_final_beat = w_beat & w_last_bit & (r_iter == LAST_ITER);
        w_lane_clear = w_clear | w_start;
    end

    // FSM state register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: a clear in CHECK keeps us in CHECK so the run restarts
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!w_run) begin
                    w_next_state = ST_IDLE;
                end else if (w_final_beat) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!w_run) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: busy tracks CHECK, so it drops on the same edge that raises done
    always_comb begin
        o_busy                   = (r_state == ST_CHECK);
        o_LaneID_Pattern_done    = r_done;
        o_REVERSAL_Result_logged = r_result;
    end

    // Bit position and symbol count shared by all lanes. A clear parks them at
    // the start of a symbol so a restarted run begins at iteration 0, bit 15.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_bit_idx <= FIRST_BIT;
            r_iter    <= '0;
        end else if (w_lane_clear) begin
            r_bit_idx <= FIRST_BIT;
            r_iter    <= '0;
        end else if (w_beat) begin
            if (w_last_bit) begin
                r_bit_idx <= FIRST_BIT;
                r_iter    <= r_iter + 1'b1;
            end else begin
                r_bit_idx <= r_bit_idx - 1'b1;
            end
        end
    end

    // Logged result: survives run entry and aborts, replaced only by a completed run or a clear
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_clear) begin
            r_result <= '0;
        end else if (w_final_beat) begin
            r_result <= w_pass;
        end
    end

    // Done pulse: the final beat can only occur once per run, so this is always one cycle wide
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_final_beat;
        end
    end

    // One scoring slice per lane, each knowing its own expected Lane ID
    for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
        lane_id_lane_checker #(
            .LANE_IDX   (gl),
            .ITERATIONS (ITERATIONS),
            .MIN_MATCH  (MIN_MATCH)
        ) u_lane (
            .CLK         (CLK),
            .rst         (rst),
            .i_clear     (w_lane_clear),
            .i_beat      (w_beat),
            .i_bit_idx   (r_bit_idx),
            .i_rx_bit    (i_rx_data[gl]),
            .o_pass_next (w_pass[gl])
        );
    end

endmodule

// File: tb/tb_lane_id_pattern_checker.sv
// Bench for the Lane ID pattern comparator. Received traffic is described as
// one 16-bit word per lane per iteration; expected results come from counting
// whole-word matches against the Lane ID symbol for each lane.
module tb_lane_id_pattern_checker;

    localparam int NL    = 16;
    localparam int NI    = 128;
    localparam int MINM  = 16;
    localparam int TOTAL = NI * 16;

    typedef enum int {K_CLEAN, K_STUCK0, K_REVERSED, K_GOODITERS} kind_t;

    typedef struct {
        string       name;
        kind_t       kind;
        int          lane;
        int          arg;
        int          duty;
        logic [15:0] expResult;
    } vec_t;

    logic          CLK = 1'b0;
    logic          rst;
    logic [1:0]    i_En;
    logic [1:0]    i_Clear;
    logic          i_rx_valid;
    logic [NL-1:0] i_rx_data;
    logic [NL-1:0] o_result;
    logic          o_done;
    logic          o_busy;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] rxWords [NL][NI];
    vec_t        vecs [6];
    logic [15:0] lastRes;

    // 10 ns clock
    always #5 CLK = ~CLK;

    lane_id_pattern_checker #(
        .NUM_LANES  (NL),
        .ITERATIONS (NI),
        .MIN_MATCH  (MINM)
    ) dut (
        .CLK                        (CLK),
        .rst                        (rst),
        .i_LaneID_Pattern_En        (i_En),
        .i_Clear_Pattern_Comparator (i_Clear),
        .i_rx_valid                 (i_rx_valid),
        .i_rx_data                  (i_rx_data),
        .o_REVERSAL_Result_logged   (o_result),
        .o_LaneID_Pattern_done      (o_done),
        .o_busy                     (o_busy)
    );

    // Lane ID symbol a lane should carry
    function automatic logic [15:0] expWord(input int lane);
        return {4'hA, 8'(lane), 4'hA};
    endfunction

    // Reference model: a lane passes when enough whole received words equal its symbol
    function automatic logic [15:0] modelResult();
        logic [15:0] res;
        int cnt;
        res = '0;
        for (int l = 0; l < NL; l++) begin
            cnt = 0;
            for (int i = 0; i < NI; i++) begin
                if (rxWords[l][i] == expWord(l)) cnt++;
            end
            res[l] = (cnt >= MINM);
        end
        return res;
    endfunction

    // Single comparison with failure reporting
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Fill the received word array for one of the directed scenarios
    task automatic buildWords(input kind_t kind, input int lane, input int arg);
        for (int l = 0; l < NL; l++)
            for (int i = 0; i < NI; i++)
                rxWords[l][i] = expWord(l);
        case (kind)
            K_STUCK0: begin
                for (int i = 0; i < NI; i++) rxWords[lane][i] = 16'h0000;
            end
            K_REVERSED: begin
                for (int l = 0; l < NL; l++)
                    for (int i = 0; i < NI; i++)
                        rxWords[l][i] = expWord(NL - 1 - l);
            end
            K_GOODITERS: begin
                for (int i = arg; i < NI; i++)
                    rxWords[lane][i] = expWord(lane) ^ (16'h0001 << $urandom_range(15));
            end
            default: ;
        endcase
    endtask

    // Random traffic: per lane, a random share of clean words, often near the pass threshold
    task automatic buildRandom();
        int k;
        for (int l = 0; l < NL; l++) begin
            k = ($urandom_range(3) == 0) ? NI : int'($urandom_range(40));
            for (int i = 0; i < NI; i++) begin
                if (int'($urandom_range(NI - 1)) < k) rxWords[l][i] = expWord(l);
                else rxWords[l][i] = expWord(l) ^ (16'h0001 << $urandom_range(15));
            end
        end
    endtask

    // Enable the checker and stream stopAt valid beats, MSB first per word,
    // with random valid gaps. Optionally asserts clear with the very last beat.
    task automatic applyStimulus(input int dutyPct, input int stopAt, input bit clearAtFinal, input string tag);
        int beats, cycles, busyCycles, doneEarly, iter, idx;
        @(negedge CLK);
        i_En       = 2'b10;
        i_rx_valid = 1'b0;
        @(negedge CLK);
        checkOutput({tag, " busy rise"}, 32'(o_busy), 32'd1);
        beats = 0; cycles = 0; busyCycles = 0; doneEarly = 0;
        while (beats < stopAt && cycles < 20000) begin
            if (o_busy) busyCycles++;
            if (o_done) doneEarly++;
            if (int'($urandom_range(99)) < dutyPct) begin
                iter = beats / 16;
                idx  = 15 - (beats % 16);
                for (int l = 0; l < NL; l++) i_rx_data[l] = rxWords[l][iter][idx];
                i_rx_valid = 1'b1;
                if (clearAtFinal && beats == TOTAL - 1) i_Clear = 2'b01;
                beats++;
            end else begin
                i_rx_valid = 1'b0;
                i_rx_data  = NL'($urandom);
            end
            cycles++;
            @(negedge CLK);
        end
        i_rx_valid = 1'b0;
        i_Clear    = 2'b00;
        checkOutput({tag, " beats delivered"}, 32'(beats), 32'(stopAt));
        checkOutput({tag, " busy throughout"}, 32'(busyCycles), 32'(cycles));
        checkOutput({tag, " no early done"}, 32'(doneEarly), 32'd0);
    endtask

    // Checks after a completed run: done exactly one cycle after the last beat, then release
    task automatic finishRun(input string tag, input logic [15:0] expRes);
        checkOutput({tag, " done pulse"}, 32'(o_done), 32'd1);
        checkOutput({tag, " busy fell"}, 32'(o_busy), 32'd0);
        checkOutput({tag, " result"}, 32'(o_result), 32'(expRes));
        @(negedge CLK);
        checkOutput({tag, " done single"}, 32'(o_done), 32'd0);
        checkOutput({tag, " result held"}, 32'(o_result), 32'(expRes));
        i_En = 2'b00;
        @(negedge CLK);
        @(negedge CLK);
        checkOutput({tag, " idle busy"}, 32'(o_busy), 32'd0);
    endtask

    // Main sequence: reset, directed table, random runs, then multi-cycle corner cases
    initial begin
        rst = 1'b1; i_En = 2'b00; i_Clear = 2'b00; i_rx_valid = 1'b0; i_rx_data = '0;
        vecs[0] = '{"clean",     K_CLEAN,     0, 0,  100, 16'hFFFF};
        vecs[1] = '{"stuck3",    K_STUCK0,    3, 0,  100, 16'hFFF7};
        vecs[2] = '{"reversed",  K_REVERSED,  0, 0,  100, 16'h0000};
        vecs[3] = '{"lane5 m15", K_GOODITERS, 5, 15, 100, 16'hFFDF};
        vecs[4] = '{"lane5 m16", K_GOODITERS, 5, 16, 100, 16'hFFFF};
        vecs[5] = '{"gaps",      K_CLEAN,     0, 0,  50,  16'hFFFF};

        repeat (3) @(negedge CLK);
        checkOutput("reset result", 32'(o_result), 32'd0);
        checkOutput("reset done", 32'(o_done), 32'd0);
        checkOutput("reset busy", 32'(o_busy), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            buildWords(vecs[v].kind, vecs[v].lane, vecs[v].arg);
            applyStimulus(vecs[v].duty, TOTAL, 1'b0, vecs[v].name);
            finishRun(vecs[v].name, vecs[v].expResult);
        end

        for (int r = 0; r < 2; r++) begin
            buildRandom();
            lastRes = modelResult();
            applyStimulus(70, TOTAL, 1'b0, "random");
            finishRun("random", lastRes);
        end

        // Enable dropped mid-run: no done, previous result kept
        buildWords(K_CLEAN, 0, 0);
        applyStimulus(100, 1000, 1'b0, "abort");
        i_En = 2'b00;
        @(negedge CLK);
        checkOutput("abort busy", 32'(o_busy), 32'd0);
        checkOutput("abort done", 32'(o_done), 32'd0);
        checkOutput("abort result kept", 32'(o_result), 32'(lastRes));
        @(negedge CLK);
        checkOutput("abort no late done", 32'(o_done), 32'd0);

        applyStimulus(100, TOTAL, 1'b0, "rerun");
        finishRun("rerun", 16'hFFFF);

        // Reset in the middle of a run zeros everything without waiting for a clock
        applyStimulus(100, 300, 1'b0, "rstRun");
        checkOutput("pre-rst result", 32'(o_result), 32'hFFFF);
        rst = 1'b1;
        #1;
        checkOutput("async rst result", 32'(o_result), 32'd0);
        checkOutput("async rst busy", 32'(o_busy), 32'd0);
        checkOutput("async rst done", 32'(o_done), 32'd0);
        @(negedge CLK);
        rst  = 1'b0;
        i_En = 2'b00;
        @(negedge CLK);

        // Clean result, then clear together with the final beat of the next run
        applyStimulus(100, TOTAL, 1'b0, "preClear");
        finishRun("preClear", 16'hFFFF);
        applyStimulus(100, TOTAL, 1'b1, "clearFinal");
        checkOutput("clearFinal done", 32'(o_done), 32'd0);
        checkOutput("clearFinal result", 32'(o_result), 32'd0);
        checkOutput("clearFinal restart busy", 32'(o_busy), 32'd1);
        i_En = 2'b00;
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("clearFinal idle", 32'(o_busy), 32'd0);
        checkOutput("clearFinal no done", 32'(o_done), 32'd0);

        // Clear together with enable entry keeps the block in IDLE for that cycle
        i_En    = 2'b10;
        i_Clear = 2'b11;
        @(negedge CLK);
        checkOutput("clear blocks entry", 32'(o_busy), 32'd0);
        i_Clear = 2'b00;
        @(negedge CLK);
        checkOutput("entry after clear", 32'(o_busy), 32'd1);
        i_En = 2'b00;
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lane_id_pattern_checker.md
# lane_id_pattern_checker

Receive-side Lane ID pattern comparator for MBINIT.REVERSALMB. It checks each mainband receive lane serially against the per-lane Lane ID pattern sent by the link partner, counts error-free iterations per lane, and produces the 16-bit per-lane pass vector plus a done pulse. These outputs are consumed as the logged reversal result and the pattern-done indication. Enable and clear come from the REVERSALMB partner-side state machine.

## Interface
- NUM_LANES, 16, number of mainband data lanes checked
- ITERATIONS, 128, Lane ID symbols expected per lane per run
- MIN_MATCH, 16, minimum error-free iterations for a lane to pass (1..ITERATIONS)
- CLK  in  1  block clock; one clock domain only
- rst  in  1  asynchronous, active-high reset
- i_LaneID_Pattern_En  in  2  2'b10 = run check; any other value = idle/abort
- i_Clear_Pattern_Comparator  in  2  any nonzero value clears counters and result (see Operation)
- i_rx_valid  in  1  qualifies i_rx_data for one beat
- i_rx_data  in  NUM_LANES  one received bit per lane per beat
- o_REVERSAL_Result_logged  out  NUM_LANES  bit L = 1 when lane L passed; reset 0
- o_LaneID_Pattern_done  out  1  one-cycle pulse at run completion; reset 0
- o_busy  out  1  high in CHECK; reset 0

## Operation
- Expected symbol for lane L: {4'hA, L[7:0], 4'hA}, 16 bits, sent MSB first, ITERATIONS times back-to-back.
- FSM states: IDLE, CHECK, DONE. Reset state is IDLE.
- IDLE -> CHECK when En == 2'b10. On entry: bit index = 15, iteration = 0, per-lane error flags and match counters = 0. The result register is not cleared on entry.
- CHECK, on each beat with i_rx_valid = 1: for every lane, error flag |= (rx bit != expected bit[index]); index decrements.
- Beat at index 0 ends the iteration. For each lane whose error flag, including this beat, is 0, the match counter increments, saturating at ITERATIONS. Error flags then clear, index returns to 15, and iteration increments.
- After the beat that ends iteration ITERATIONS-1: result[L] = (match_cnt[L] >= MIN_MATCH). Pulse done. Go to DONE.
- Beats with i_rx_valid = 0 stall. No state changes.
- DONE -> IDLE when En != 2'b10. The result holds until the next clear or the next completed run.
- CHECK with En != 2'b10 -> IDLE. The run is abandoned, there is no done pulse, and the result is unchanged.
- Clear (nonzero) in any state zeros the result, match counters, error flags, index and iteration. In CHECK, the run restarts at iteration 0, index 15, on the next cycle.
- Simultaneous events:
  - Clear wins over a final beat: no done, result = 0.
  - Clear wins over enable entry: stay IDLE that cycle.
- Match counter width is $clog2(ITERATIONS+1). Iteration counter width is $clog2(ITERATIONS).

## Timing
- Done pulse and result update occur on the clock edge that samples the final valid beat. Both are visible the following cycle. Latency from the last beat is 1 cycle.
- The minimum run is 16×ITERATIONS valid beats (2048 at defaults).
- o_busy rises the cycle after En becomes 2'b10. It falls together with the done pulse.
- rst asserted mid-run forces IDLE and zeros all outputs immediately (asynchronous). Release is synchronous to CLK.
- Done is never asserted for two consecutive cycles.

## Structure
- Shared package: FSM state enum, LANEID_PREFIX = 4'hA, symbol width 16, and the En encoding constant (2'b10).
- Sub-module: lane_id_lane_checker, instantiated NUM_LANES times. It holds the error flag and match counter for one lane, with the lane index as a parameter.
- The top level holds the FSM, bit index, iteration counter and result register.

## Test plan
- Perfect patterns on all 16 lanes, continuous valid → result 16'hFFFF; done pulses exactly 1 cycle after beat 2048; o_busy high for 2048 cycles.
- Lane 3 stuck at 0, others clean → result 16'hFFF7. Lanes fully reversed (lane L receives lane 15-L pattern) → result 16'h0000 (prefix/suffix match, ID differs).
- Lane 5 error-free in exactly 15 iterations → bit 5 = 0. Same with 16 → bit 5 = 1 (MIN_MATCH boundary).
- Random i_rx_valid gaps (≈50% duty) with clean data → result 16'hFFFF; done 1 cycle after the 2048th valid beat.
- En dropped at beat 1000 → no done, prior result kept. Re-enable and run clean → 16'hFFFF.
- Clear coincident with the final beat → no done, result 16'h0000. rst asserted mid-CHECK → all outputs 0 that cycle.
